// File: rtl/seg7_scan_ctrl.sv
// Four-digit multiplexed 7-segment scanner with frame-synchronous double-buffered update.
// Optional leading-zero blanking is enabled by defining SEG7_LZ_BLANK_EN.
module seg7_scan_ctrl #(
    parameter int DIV = 8,
    parameter int GAP = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [15:0] wr_data,
    input  logic [3:0]  wr_dp,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        pend,
    output logic        frame_tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
    localparam logic [CW-1:0] GAP_C   = CW'(GAP);

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } state_t;

    state_t        st, st_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [1:0]    dig, dig_nxt;
    logic [15:0]   disp, disp_nxt;
    logic [3:0]    disp_dp, disp_dp_nxt;
    logic [15:0]   shadow;
    logic [3:0]    shadow_dp;
    logic [6:0]    seg_nxt;
    logic          dp_nxt;
    logic [3:0]    an_nxt;
    logic          tick_nxt;
    logic [3:0]    nib;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] r;
        r = 7'h7F;
        case (d)
            4'h0: r = 7'h01;
            4'h1: r = 7'h4F;
            4'h2: r = 7'h12;
            4'h3: r = 7'h06;
            4'h4: r = 7'h4C;
            4'h5: r = 7'h24;
            4'h6: r = 7'h20;
            4'h7: r = 7'h0F;
            4'h8: r = 7'h00;
            4'h9: r = 7'h04;
            4'hA: r = 7'h08;
            4'hB: r = 7'h60;
            4'hC: r = 7'h31;
            4'hD: r = 7'h42;
            4'hE: r = 7'h30;
            4'hF: r = 7'h38;
        endcase
        return r;
    endfunction

`ifdef SEG7_LZ_BLANK_EN
    // A digit is suppressed only if it and everything to its left is zero
    // and it carries no decimal point; the rightmost digit always shows.
    function automatic logic lz_blank(input logic [1:0] d, input logic [15:0] v,
                                      input logic [3:0] p);
        logic r;
        r = 1'b0;
        case (d)
            2'd3: r = (v[15:12] == 4'h0) && !p[3];
            2'd2: r = (v[15:8] == 8'h00) && !p[2];
            2'd1: r = (v[15:4] == 12'h000) && !p[1];
            default: r = 1'b0;
        endcase
        return r;
    endfunction
`endif

    // Slot counter and digit index advance
    always_comb begin
        cnt_nxt = cnt + CW'(1);
        dig_nxt = dig;
        if (cnt == CNT_MAX) begin
            cnt_nxt = '0;
            dig_nxt = dig + 2'd1;
        end
    end

    // Commit on the frame_tick cycle; a write in that same cycle wins
    always_comb begin
        disp_nxt    = disp;
        disp_dp_nxt = disp_dp;
        if (frame_tick) begin
            if (wr_en) begin
                disp_nxt    = wr_data;
                disp_dp_nxt = wr_dp;
            end else if (pend) begin
                disp_nxt    = shadow;
                disp_dp_nxt = shadow_dp;
            end
        end
    end

    // Next-state logic: leave BLANK once the gap has elapsed, return on wrap
    always_comb begin
        st_nxt = st;
        case (st)
            BLANK: if (cnt_nxt == GAP_C) st_nxt = DRIVE;
            DRIVE: if (cnt_nxt == '0) st_nxt = BLANK;
            default: st_nxt = BLANK;
        endcase
    end

    // Output decode from post-edge state so the registered outputs carry no extra latency
    always_comb begin
        an_nxt   = 4'b1111;
        seg_nxt  = 7'h7F;
        dp_nxt   = 1'b1;
        nib      = disp_nxt[{dig_nxt, 2'b00} +: 4];
        tick_nxt = (dig_nxt == 2'd3) && (cnt_nxt == CNT_MAX);
`ifdef SEG7_LZ_BLANK_EN
        if ((st_nxt == DRIVE) && !lz_blank(dig_nxt, disp_nxt, disp_dp_nxt)) begin
`else
        if (st_nxt == DRIVE) begin
`endif
            an_nxt[dig_nxt] = 1'b0;
            seg_nxt         = decode(nib);
            dp_nxt          = ~disp_dp_nxt[dig_nxt];
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st         <= BLANK;
            cnt        <= '0;
            dig        <= 2'd0;
            disp       <= 16'h0000;
            disp_dp    <= 4'h0;
            shadow     <= 16'h0000;
            shadow_dp  <= 4'h0;
            pend       <= 1'b0;
            frame_tick <= 1'b0;
            an         <= 4'b1111;
            seg        <= 7'h7F;
            dp         <= 1'b1;
        end else begin
            st         <= st_nxt;
            cnt        <= cnt_nxt;
            dig        <= dig_nxt;
            disp       <= disp_nxt;
            disp_dp    <= disp_dp_nxt;
            if (wr_en) begin
                shadow    <= wr_data;
                shadow_dp <= wr_dp;
            end
            if (frame_tick)
                pend <= 1'b0;
            else if (wr_en)
                pend <= 1'b1;
            frame_tick <= tick_nxt;
            an         <= an_nxt;
            seg        <= seg_nxt;
            dp         <= dp_nxt;
        end
    end

endmodule
